varredura_matriz_param: RTL and testbench
=========================================

Name: varredura_matriz_param

Overview:
Parametrised LED-matrix scan controller, the next generation of the fixed 7x5 scanner. It time-multiplexes an N-row x M-column matrix with active-low row drive and active-high column drive. Pixel data comes from an internal double-buffered frame memory rather than hard-wired frames. It adds an internal row-dwell prescaler, an anti-ghosting blanking interval, a valid/ready write port, and tear-free buffer swap at frame boundaries.

Parameters:
LINHAS, 7, number of matrix rows (>=2)
COLUNAS, 5, number of matrix columns (>=1)
ADDR_W, 3, row-index width; 2**ADDR_W >= LINHAS
DIV_LINHA, 50000, clock cycles each row is driven (>=1)
BLANK, 500, blanking cycles between rows (0 = no blanking)

Ports:
clock_50MHz  in  1  system clock
reset  in  1  synchronous, active-high reset
habilita  in  1  1 = scan runs; 0 = matrix dark, scan parked
wr_valid  in  1  write request
wr_ready  out  1  write accepted when wr_valid & wr_ready at clock edge
wr_linha  in  ADDR_W  back-buffer row address
wr_dados  in  COLUNAS  row pixel data, bit i = column i on
troca  in  1  request back/front buffer swap
troca_pendente  out  1  swap requested, not yet executed
linhas  out  LINHAS  row drive, active-low, at most one bit low
colunas  out  COLUNAS  column drive, active-high
linha_atual  out  ADDR_W  index of row being scanned
fim_quadro  out  1  one-cycle pulse at frame boundary

Behaviour:
- One clock (clock_50MHz). Reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - linhas = all 1s; colunas = 0; linha_atual = 0
  - fim_quadro = 0; troca_pendente = 0; wr_ready = 1
  - both buffer banks cleared to 0; front bank = bank 0
  - FSM = PARADO; dwell counter = 0
- Memory: two banks of LINHAS x COLUNAS bits.
  - Writes always target the back bank. The display always reads the front bank.
  - Accepted write with wr_linha >= LINHAS: handshake completes, data discarded.
- wr_ready = ~troca_pendente. The back bank is frozen while a swap is pending.
- troca sampled high while troca_pendente = 0 sets troca_pendente at the next edge.
- troca while already pending: ignored.
- troca and an accepted write in the same cycle: the write lands in the current back bank first, then the swap becomes pending.
- FSM states: PARADO, ATIVO, APAGADO.
  - PARADO:
    - linhas all 1s, colunas 0, linha_atual 0.
    - Any pending swap executes here: bank pointer toggles, troca_pendente clears.
    - Exits to ATIVO(row 0) on the first edge with habilita = 1.
  - ATIVO(r):
    - linhas = all 1s except bit r = 0; colunas = front[r]; linha_atual = r.
    - Held exactly DIV_LINHA cycles.
    - Then goes to APAGADO, or directly to the next ATIVO if BLANK = 0.
  - APAGADO:
    - linhas all 1s, colunas 0, linha_atual holds r.
    - Held exactly BLANK cycles, then goes to ATIVO((r+1) mod LINHAS).
- Row period = DIV_LINHA + BLANK; frame period = LINHAS x row period.
- Frame boundary = transition out of the last row (r = LINHAS-1) into row 0. At that edge:
  - fim_quadro = 1 for exactly one cycle.
  - A pending swap executes: front pointer toggles, troca_pendente -> 0, wr_ready -> 1.
  - Row 0 of the new frame shows the new front bank.
- A swap never executes mid-frame while habilita = 1 (no tearing).
- Column data is sampled from the front bank at entry to ATIVO. Back-bank writes never disturb the displayed image.
- habilita -> 0 in any state: the next edge goes to PARADO (dark) and counters clear.
- Re-enable always restarts at row 0 with a full dwell.
- fim_quadro never pulses on a habilita-driven exit.
- reset mid-frame or mid-swap: returns to reset values at the next edge. Buffer contents are lost.

Test Plan:
(Bench parameters: LINHAS=7, COLUNAS=5, DIV_LINHA=4, BLANK=2; row period 6, frame 42 cycles.)
- Reset, then habilita=1 -> linhas=7'b1111110 and colunas=0 for 4 cycles, then linhas=7'h7F for 2 cycles, then 7'b1111101. fim_quadro pulses every 42 cycles.
- Write rows 0..6 = 5'h11,5'h0A,5'h04,5'h0A,5'h11,5'h1F,5'h00, pulse troca mid-frame -> wr_ready=0 until the frame boundary. At the boundary troca_pendente falls, and the next frame shows the X pattern (colunas=5'h11 while row 0 is low).
- With troca pending, hold wr_valid=1, wr_linha=0, wr_dados=5'h1F -> no acceptance until the swap. Accepted next cycle into the new back bank; display unchanged until the next swap.
- Drop habilita mid-row 3 -> linhas=7'h7F, colunas=0 the next cycle, no fim_quadro. Re-raise -> row 0 driven for a full 4 cycles.
- troca in PARADO with habilita=0 -> swap executes the next cycle. wr_linha=7 write -> accepted and discarded, memory unchanged.
- Assert reset mid-APAGADO with a swap pending -> all outputs at reset values after one edge, troca_pendente=0, display blank after restart.

Source files
------------

// File: rtl/varredura_matriz_param.sv
// Parametrised LED-matrix scanner: active-low rows, active-high columns, double-buffered
// frame memory with a valid/ready write port and tear-free buffer swap at frame boundaries.
module varredura_matriz_param #(
  parameter int unsigned LINHAS    = 7,
  parameter int unsigned COLUNAS   = 5,
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned DIV_LINHA = 50000,
  parameter int unsigned BLANK     = 500
) (
  input  logic               clock_50MHz,
  input  logic               reset,
  input  logic               habilita,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [ADDR_W-1:0]  wr_linha,
  input  logic [COLUNAS-1:0] wr_dados,
  input  logic               troca,
  output logic               troca_pendente,
  output logic [LINHAS-1:0]  linhas,
  output logic [COLUNAS-1:0] colunas,
  output logic [ADDR_W-1:0]  linha_atual,
  output logic               fim_quadro
);

  localparam int unsigned CntMax    = (DIV_LINHA > BLANK) ? DIV_LINHA : BLANK;
  localparam int unsigned CntW      = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned DivLast   = DIV_LINHA - 1;
  // Guarded so BLANK = 0 does not underflow; APAGADO is unreachable in that case.
  localparam int unsigned BlankLast = (BLANK == 0) ? 0 : BLANK - 1;

  typedef enum logic [1:0] {StParado, StAtivo, StApagado} estado_e;

  estado_e             state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]   row_q, row_d, row_nxt;
  logic                row_last;
  logic                front_q, front_d;
  logic                pend_q, pend_d;
  logic                ready_q, ready_d;
  logic                fim_q, fim_d;
  logic [LINHAS-1:0]   linhas_q, linhas_d;
  logic [COLUNAS-1:0]  colunas_q, colunas_d;
  logic                swap;
  logic                wr_acc;
  logic [COLUNAS-1:0]  mem_q [2][LINHAS];

  assign row_last = (row_q == ADDR_W'(LINHAS - 1));
  assign row_nxt  = row_last ? '0 : row_q + ADDR_W'(1);
  // Handshake always completes; out-of-range rows are simply dropped.
  assign wr_acc   = wr_valid & ready_q;

  // Scan FSM next state, swap scheduling and registered output values
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_d     = row_q;
    fim_d     = 1'b0;
    swap      = 1'b0;
    linhas_d  = '1;
    colunas_d = '0;

    unique case (state_q)
      StParado: begin
        row_d = '0;
        cnt_d = '0;
        swap  = pend_q;
        if (habilita) state_d = StAtivo;
      end
      StAtivo: begin
        if (cnt_q == CntW'(DivLast)) begin
          cnt_d = '0;
          if (BLANK == 0) begin
            row_d = row_nxt;
            fim_d = row_last;
            swap  = row_last & pend_q;
          end else begin
            state_d = StApagado;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StApagado: begin
        if (cnt_q == CntW'(BlankLast)) begin
          cnt_d   = '0;
          state_d = StAtivo;
          row_d   = row_nxt;
          fim_d   = row_last;
          swap    = row_last & pend_q;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StParado;
    endcase

    // Disable wins over everything: go dark, no frame pulse, swap only from PARADO.
    if (!habilita) begin
      state_d = StParado;
      cnt_d   = '0;
      row_d   = '0;
      fim_d   = 1'b0;
      swap    = (state_q == StParado) & pend_q;
    end

    front_d = front_q ^ swap;
    if (swap)                 pend_d = 1'b0;
    else if (!pend_q && troca) pend_d = 1'b1;
    else                      pend_d = pend_q;
    ready_d = ~pend_d;

    if (state_d == StAtivo) begin
      linhas_d[row_d] = 1'b0;
      // front_d so a swap executed on the same edge is already visible on row 0.
      colunas_d       = mem_q[front_d][row_d];
    end
  end

  // Control and output registers
  always_ff @(posedge clock_50MHz) begin
    if (reset) begin
      state_q   <= StParado;
      cnt_q     <= '0;
      row_q     <= '0;
      front_q   <= 1'b0;
      pend_q    <= 1'b0;
      ready_q   <= 1'b1;
      fim_q     <= 1'b0;
      linhas_q  <= '1;
      colunas_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      front_q   <= front_d;
      pend_q    <= pend_d;
      ready_q   <= ready_d;
      fim_q     <= fim_d;
      linhas_q  <= linhas_d;
      colunas_q <= colunas_d;
    end
  end

  // Frame memory: writes only ever land in the back bank
  always_ff @(posedge clock_50MHz) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < int'(LINHAS); r++) begin
          mem_q[b][r] <= '0;
        end
      end
    end else if (wr_acc && (32'(wr_linha) < LINHAS)) begin
      mem_q[~front_q][wr_linha] <= wr_dados;
    end
  end

  assign wr_ready       = ready_q;
  assign troca_pendente = pend_q;
  assign linhas         = linhas_q;
  assign colunas        = colunas_q;
  assign linha_atual    = row_q;
  assign fim_quadro     = fim_q;

endmodule

// File: tb/tb_varredura_matriz_param.sv
// Directed bench for varredura_matriz_param with a short dwell (4) and blanking (2).
module tb_varredura_matriz_param;

  localparam int unsigned LINHAS = 7;
  localparam int unsigned COLUNAS = 5;
  localparam int unsigned ADDR_W = 3;

  logic               clk = 1'b0;
  logic               reset, habilita, wr_valid, wr_ready, troca, troca_pendente, fim_quadro;
  logic [ADDR_W-1:0]  wr_linha, linha_atual;
  logic [COLUNAS-1:0] wr_dados, colunas;
  logic [LINHAS-1:0]  linhas;

  int n_checks = 0;
  int n_pass   = 0;
  int e        = 0;

  logic [COLUNAS-1:0] pat [7] = '{5'h11, 5'h0A, 5'h04, 5'h0A, 5'h11, 5'h1F, 5'h00};

  varredura_matriz_param #(
    .LINHAS(LINHAS), .COLUNAS(COLUNAS), .ADDR_W(ADDR_W), .DIV_LINHA(4), .BLANK(2)
  ) u_dut (
    .clock_50MHz    (clk),
    .reset          (reset),
    .habilita       (habilita),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_linha       (wr_linha),
    .wr_dados       (wr_dados),
    .troca          (troca),
    .troca_pendente (troca_pendente),
    .linhas         (linhas),
    .colunas        (colunas),
    .linha_atual    (linha_atual),
    .fim_quadro     (fim_quadro)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // One clock edge; outputs are sampled 1 ns later, inputs changed there too.
  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic run_to(input int target);
    while (e < target) tick();
  endtask

  initial begin
    reset = 1'b1; habilita = 1'b0; wr_valid = 1'b0; wr_linha = '0; wr_dados = '0; troca = 1'b0;
    tick();
    check_eq("rst_linhas", linhas, 7'h7F);
    check_eq("rst_colunas", colunas, 5'h00);
    check_eq("rst_linha_atual", linha_atual, 3'd0);
    check_eq("rst_fim", fim_quadro, 1'b0);
    check_eq("rst_pend", troca_pendente, 1'b0);
    check_eq("rst_ready", wr_ready, 1'b1);
    reset = 1'b0;

    // Basic scan timing
    habilita = 1'b1;
    e = 0;
    tick();
    check_eq("e1_linhas", linhas, 7'h7E);
    check_eq("e1_colunas", colunas, 5'h00);
    run_to(4);
    check_eq("e4_linhas", linhas, 7'h7E);
    run_to(5);
    check_eq("e5_blank", linhas, 7'h7F);
    check_eq("e5_linha_atual", linha_atual, 3'd0);
    run_to(6);
    check_eq("e6_blank", linhas, 7'h7F);
    run_to(7);
    check_eq("e7_linhas", linhas, 7'h7D);
    check_eq("e7_linha_atual", linha_atual, 3'd1);

    // Fill back bank with the X pattern, then request a swap mid-frame
    for (int i = 0; i < 7; i++) begin
      wr_valid = 1'b1; wr_linha = 3'(i); wr_dados = pat[i];
      tick();
    end
    wr_valid = 1'b0;
    troca = 1'b1;
    tick();
    troca = 1'b0;
    check_eq("e15_pend", troca_pendente, 1'b1);
    check_eq("e15_ready", wr_ready, 1'b0);
    wr_valid = 1'b1; wr_linha = 3'd0; wr_dados = 5'h1F;
    run_to(37);
    check_eq("e37_linhas", linhas, 7'h3F);
    check_eq("e37_old_front", colunas, 5'h00);
    check_eq("e37_ready", wr_ready, 1'b0);
    run_to(42);
    check_eq("e42_pend", troca_pendente, 1'b1);
    check_eq("e42_fim", fim_quadro, 1'b0);
    run_to(43);
    check_eq("e43_fim", fim_quadro, 1'b1);
    check_eq("e43_pend", troca_pendente, 1'b0);
    check_eq("e43_ready", wr_ready, 1'b1);
    check_eq("e43_linhas", linhas, 7'h7E);
    check_eq("e43_colunas", colunas, 5'h11);
    run_to(44);
    wr_valid = 1'b0;
    check_eq("e44_fim", fim_quadro, 1'b0);
    check_eq("e44_colunas", colunas, 5'h11);
    run_to(49);
    check_eq("e49_linhas", linhas, 7'h7D);
    check_eq("e49_colunas", colunas, 5'h0A);
    run_to(73);
    check_eq("e73_linhas", linhas, 7'h5F);
    check_eq("e73_colunas", colunas, 5'h1F);
    run_to(85);
    check_eq("e85_fim", fim_quadro, 1'b1);
    check_eq("e85_colunas", colunas, 5'h11);

    // Disable in the middle of row 3
    run_to(104);
    check_eq("e104_linhas", linhas, 7'h77);
    check_eq("e104_colunas", colunas, 5'h0A);
    habilita = 1'b0;
    tick();
    check_eq("off_linhas", linhas, 7'h7F);
    check_eq("off_colunas", colunas, 5'h00);
    check_eq("off_fim", fim_quadro, 1'b0);
    check_eq("off_linha_atual", linha_atual, 3'd0);
    tick();
    check_eq("off2_fim", fim_quadro, 1'b0);

    // Re-enable: full dwell on row 0
    habilita = 1'b1;
    e = 0;
    tick();
    check_eq("re1_linhas", linhas, 7'h7E);
    check_eq("re1_colunas", colunas, 5'h11);
    run_to(4);
    check_eq("re4_linhas", linhas, 7'h7E);
    run_to(5);
    check_eq("re5_linhas", linhas, 7'h7F);

    // Swap while parked
    habilita = 1'b0;
    tick();
    troca = 1'b1;
    tick();
    troca = 1'b0;
    check_eq("park_pend", troca_pendente, 1'b1);
    check_eq("park_ready", wr_ready, 1'b0);
    tick();
    check_eq("park_swapped", troca_pendente, 1'b0);
    check_eq("park_ready2", wr_ready, 1'b1);
    habilita = 1'b1;
    tick();
    check_eq("bank0_row0", colunas, 5'h1F);
    habilita = 1'b0;
    tick();

    // Out-of-range row write: handshake completes, nothing stored
    wr_valid = 1'b1; wr_linha = 3'd7; wr_dados = 5'h1F;
    tick();
    wr_valid = 1'b0;
    check_eq("oor_ready", wr_ready, 1'b1);
    check_eq("oor_pend", troca_pendente, 1'b0);
    troca = 1'b1;
    tick();
    troca = 1'b0;
    tick();
    habilita = 1'b1;
    e = 0;
    tick();
    check_eq("bank1_row0", colunas, 5'h11);

    // Reset during blanking with a swap pending
    run_to(5);
    check_eq("blank_linhas", linhas, 7'h7F);
    troca = 1'b1;
    tick();
    troca = 1'b0;
    check_eq("blank_pend", troca_pendente, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("rst2_linhas", linhas, 7'h7F);
    check_eq("rst2_colunas", colunas, 5'h00);
    check_eq("rst2_pend", troca_pendente, 1'b0);
    check_eq("rst2_ready", wr_ready, 1'b1);
    check_eq("rst2_linha_atual", linha_atual, 3'd0);
    tick();
    check_eq("rst2_run_linhas", linhas, 7'h7E);
    check_eq("rst2_run_colunas", colunas, 5'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
